// File: rtl/lddn_ctr.sv
// Loadable, cascadable binary down-counter slice with optional auto-reload
// and a registered terminal-count strobe; slices chain through BI/BO.
module lddn_ctr #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             SP,
    input  logic             SD,
    input  logic [WIDTH-1:0] D,
    input  logic             BI,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             ZERO,
    output logic             TC
);

    logic [WIDTH-1:0] q_q,   q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q,  tc_d;
    logic             zero_w;

    assign zero_w = (q_q == '0);

    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        q_d   = q_q;
        rld_d = rld_q;
        tc_d  = 1'b0;
        if (SP) begin
            if (SD) begin
                q_d   = D;
                rld_d = D;
            end else if (BI) begin
                if (zero_w) begin
                    q_d  = AUTO_RELOAD ? rld_q : '1;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CK) begin
        if (CD) begin
            q_q   <= '0;
            rld_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            rld_q <= rld_d;
            tc_q  <= tc_d;
        end
    end

    // Borrow path stays free of SP/SD so a shared-enable chain ripples in one cycle.
    assign Q    = q_q;
    assign ZERO = zero_w;
    assign BO   = BI & zero_w;
    assign TC   = tc_q;

endmodule

// File: tb/tb_lddn_ctr.sv
// Self-checking bench: plain-arithmetic reference for an 8-bit wrapping
// counter, an 8-bit auto-reload counter and a two-slice 4-bit cascade.
module tb_lddn_ctr;

    logic       clk = 1'b0;
    logic       cd, sp, sd, bi;
    logic [7:0] d;

    logic [7:0] q8, qa;
    logic       bo8, z8, tc8, boa, za, tca;
    logic [3:0] ql, qh;
    logic       bol, zl, tcl, boh, zh, tch;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // reference state
    logic [7:0] m_q, m_rld, a_q, a_rld;
    logic       m_tc, a_tc, lo_tc;

    always #5 clk = ~clk;

    lddn_ctr #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_wrap (
        .CK(clk), .CD(cd), .SP(sp), .SD(sd), .D(d), .BI(bi),
        .Q(q8), .BO(bo8), .ZERO(z8), .TC(tc8));

    lddn_ctr #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_arld (
        .CK(clk), .CD(cd), .SP(sp), .SD(sd), .D(d), .BI(bi),
        .Q(qa), .BO(boa), .ZERO(za), .TC(tca));

    lddn_ctr #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_lo (
        .CK(clk), .CD(cd), .SP(sp), .SD(sd), .D(d[3:0]), .BI(bi),
        .Q(ql), .BO(bol), .ZERO(zl), .TC(tcl));

    lddn_ctr #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_hi (
        .CK(clk), .CD(cd), .SP(sp), .SD(sd), .D(d[7:4]), .BI(bol),
        .Q(qh), .BO(boh), .ZERO(zh), .TC(tch));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counter value as an integer modulo 256; underflow is a
    // decrement request seen while the value is zero.
    always @(posedge clk) begin
        if (cd) begin
            m_q <= 8'd0; m_rld <= 8'd0; m_tc <= 1'b0;
            a_q <= 8'd0; a_rld <= 8'd0; a_tc <= 1'b0;
            lo_tc <= 1'b0;
        end else begin
            m_tc  <= sp && !sd && bi && (m_q == 8'd0);
            a_tc  <= sp && !sd && bi && (a_q == 8'd0);
            lo_tc <= sp && !sd && bi && (int'(m_q) % 16 == 0);
            if (sp && sd) begin
                m_q <= d; m_rld <= d;
                a_q <= d; a_rld <= d;
            end else if (sp && bi) begin
                m_q <= 8'((int'(m_q) + 255) % 256);
                a_q <= (a_q == 8'd0) ? a_rld : 8'(int'(a_q) - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wrap_q",     q8,        m_q);
            check("wrap_tc",    tc8,       m_tc);
            check("wrap_zero",  z8,        m_q == 8'd0);
            check("wrap_bo",    bo8,       bi && m_q == 8'd0);
            check("arld_q",     qa,        a_q);
            check("arld_tc",    tca,       a_tc);
            check("arld_bo",    boa,       bi && a_q == 8'd0);
            check("arld_zero",  za,        a_q == 8'd0);
            check("casc_q",     {qh, ql},  m_q);
            check("casc_hi_tc", tch,       m_tc);
            check("casc_lo_tc", tcl,       lo_tc);
            check("casc_lo_bo", bol,       bi && m_q[3:0] == 4'd0);
            check("casc_hi_bo", boh,       bi && m_q == 8'd0);
            check("casc_zero",  {zh, zl},  {m_q[7:4] == 4'd0, m_q[3:0] == 4'd0});
        end
    end

    task automatic drive(input logic c, input logic p, input logic s,
                         input logic [7:0] dv, input logic b);
        cd = c; sp = p; sd = s; d = dv; bi = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] exp_w [5];
        logic       exp_t [5];
        logic [7:0] exp_a [6];

        // reset with a competing load
        drive(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_q", q8, 8'h00);
        check("rst_tc", tc8, 1'b0);
        check("rst_arld_q", qa, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        check("rst_zero", z8, 1'b1);
        check("rst_bo_hi", bo8, 1'b1);
        bi = 1'b0;
        #1;
        check("rst_bo_lo", bo8, 1'b0);

        // load 3 then count through the wrap
        drive(1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
        tick();
        check("load3_q", q8, 8'd3);
        exp_w = '{8'd2, 8'd1, 8'd0, 8'hFF, 8'hFE};
        exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("cnt_q", q8, exp_w[i]);
            check("cnt_tc", tc8, exp_t[i]);
        end

        // auto-reload period of three
        drive(1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
        tick();
        check("arld_load", qa, 8'd2);
        exp_a = '{8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2};
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arld_seq_q", qa, exp_a[i]);
            check("arld_seq_tc", tca, (exp_a[i] == 8'd2));
        end

        // enable hold and load priority
        drive(1'b0, 1'b1, 1'b1, 8'd5, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, i[0], 8'($urandom), ~i[0]);
            tick();
            check("hold_q", q8, 8'd5);
            check("hold_tc", tc8, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 8'd9, 1'b1);
        tick();
        check("load_over_dec", q8, 8'd9);
        drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h33, 1'b1);
        tick();
        check("load_at_zero_q", q8, 8'h33);
        check("load_at_zero_tc", tc8, 1'b0);

        // cascade borrow across the nibble boundary
        drive(1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        check("casc_0f", {qh, ql}, 8'h0F);
        tick();
        check("casc_0e", {qh, ql}, 8'h0E);
        check("casc_hi_hold", qh, 4'h0);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        check("casc_wrap", {qh, ql}, 8'hFF);
        check("casc_wrap_tc", tch, 1'b1);

        // reset mid-count wins over a decrement
        drive(1'b0, 1'b1, 1'b1, 8'd7, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        tick();
        check("mid_q5", q8, 8'd5);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        check("mid_rst_q", q8, 8'd0);
        check("mid_rst_tc", tc8, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick();
        check("mid_wrap_q", q8, 8'hFF);
        check("mid_wrap_tc", tc8, 1'b1);
        check("mid_arld_q", qa, 8'd0);
        check("mid_arld_tc", tca, 1'b1);
        tick();
        check("arld_zero_q", qa, 8'd0);
        check("arld_zero_tc", tca, 1'b1);

        // randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 8), 8'($urandom),
                  ($urandom_range(0, 99) < 75));
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
